data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder
// ----------------------------------------------------------------------------
// Purpose
//   This is a single-port data memory slave with a fixed response latency.
//   The block accepts one load or store in IDLE. It waits WAIT_CYCLES cycles,
//   then performs the access on the edge that enters RESP. During RESP it
//   presents a one-cycle rvalid pulse with the result.
//   Byte, half and word accesses are supported. Loads can be sign- or
//   zero-extended. An access faults when:
//     - the size encoding is reserved,
//     - the address is misaligned, or
//     - the address lies outside the array.
//   A faulting access sets err, returns rdata=0 and leaves the array unchanged.
//
// Parameters
//   WAIT_CYCLES : wait states between acceptance and response (0..15)
//   DEPTH       : number of 32-bit words in the storage array
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset. It also clears the array.
//   req        in   request strobe. It is accepted when ready=1.
//   we         in   1 = store, 0 = load
//   addr[31:0] in   byte address
//   size[1:0]  in   00 byte, 01 half, 10 word, 11 reserved
//   signed_ld  in   sign-extend byte/half loads
//   wdata[31:0]in   right-justified store data
//   ready      out  high only in IDLE
//   rvalid     out  one-cycle completion pulse (RESP)
//   rdata[31:0]out  load result. It holds until the next response.
//   err        out  access fault. It is meaningful while rvalid=1.
// ============================================================================
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        signed_ld,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;
    localparam bit          NO_WAIT    = (WAIT_CYCLES == 0);
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic        cap_we_reg;
    logic [31:0] cap_addr_reg;
    logic [1:0]  cap_size_reg;
    logic        cap_signed_reg;
    logic [31:0] cap_wdata_reg;

    logic        ready_reg;
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    // Reset must clear every word, so the array is built from flops
    // rather than a RAM macro.
    logic [31:0] mem_reg [DEPTH];

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    // With zero wait states, the access happens on the accepting edge
    // itself. The capture registers are not loaded yet at that point,
    // so the live inputs are used while in IDLE.
    logic        in_idle;
    logic        accept;
    logic        enter_resp;
    logic        op_we;
    logic [31:0] op_addr;
    logic [1:0]  op_size;
    logic        op_signed;
    logic [31:0] op_wdata;

    assign in_idle   = (state_reg == IDLE);
    assign accept    = req & ready_reg;
    assign op_we     = in_idle ? we        : cap_we_reg;
    assign op_addr   = in_idle ? addr      : cap_addr_reg;
    assign op_size   = in_idle ? size      : cap_size_reg;
    assign op_signed = in_idle ? signed_ld : cap_signed_reg;
    assign op_wdata  = in_idle ? wdata     : cap_wdata_reg;

    assign enter_resp = (in_idle && accept && NO_WAIT) ||
                        ((state_reg == WAIT) && (wait_cnt_reg == 4'd0));

    // ------------------------------------------------------------------
    // Fault detection
    // ------------------------------------------------------------------
    logic fault;

    always_comb begin
        fault = 1'b0;
        case (op_size)
            SIZE_BYTE: fault = 1'b0;
            SIZE_HALF: fault = op_addr[0];
            SIZE_WORD: fault = (op_addr[1:0] != 2'b00);
            default:   fault = 1'b1;
        endcase
        // The range check is done at 33 bits so that a DEPTH which
        // fills the whole 32-bit space cannot wrap the limit.
        if ({1'b0, op_addr} >= ADDR_LIMIT) begin
            fault = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read path: word fetch, lane alignment, extension
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] op_idx;
    logic [31:0]      rd_word;
    logic [4:0]       lane_shamt;
    logic [15:0]      rd_lanes;
    logic [31:0]      load_data;

    assign op_idx  = op_addr[IDX_W+1:2];
    assign rd_word = mem_reg[op_idx];

    always_comb begin
        lane_shamt = 5'd0;
        case (op_size)
            SIZE_BYTE: lane_shamt = {op_addr[1:0], 3'b000};
            SIZE_HALF: lane_shamt = {op_addr[1], 4'b0000};
            default:   lane_shamt = 5'd0;
        endcase
    end

    assign rd_lanes = 16'(rd_word >> lane_shamt);

    always_comb begin
        load_data = rd_word;
        case (op_size)
            SIZE_BYTE: load_data = {{24{op_signed & rd_lanes[7]}},  rd_lanes[7:0]};
            SIZE_HALF: load_data = {{16{op_signed & rd_lanes[15]}}, rd_lanes[15:0]};
            default:   load_data = rd_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Write path: byte enables and lane replication
    // ------------------------------------------------------------------
    // The store data is replicated across all lanes. The byte enable
    // then picks which lanes land. This avoids a variable shift on the
    // write data.
    logic [3:0]  wr_be;
    logic [31:0] wr_lanes;
    logic [31:0] merged_word;
    logic        commit;

    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = op_wdata;
        case (op_size)
            SIZE_BYTE: begin
                wr_be    = 4'b0001 << op_addr[1:0];
                wr_lanes = {4{op_wdata[7:0]}};
            end
            SIZE_HALF: begin
                wr_be    = op_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{op_wdata[15:0]}};
            end
            SIZE_WORD: begin
                wr_be    = 4'b1111;
                wr_lanes = op_wdata;
            end
            default: begin
                wr_be    = 4'b0000;
                wr_lanes = op_wdata;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_merge
            assign merged_word[8*gi +: 8] = wr_be[gi] ? wr_lanes[8*gi +: 8]
                                                      : rd_word[8*gi +: 8];
        end
    endgenerate

    assign commit = enter_resp & op_we & ~fault;

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (commit) begin
            mem_reg[op_idx] <= merged_word;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= 4'd0;
            cap_we_reg     <= 1'b0;
            cap_addr_reg   <= '0;
            cap_size_reg   <= 2'b00;
            cap_signed_reg <= 1'b0;
            cap_wdata_reg  <= '0;
            ready_reg      <= 1'b1;
            rvalid_reg     <= 1'b0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cap_we_reg     <= we;
                        cap_addr_reg   <= addr;
                        cap_size_reg   <= size;
                        cap_signed_reg <= signed_ld;
                        cap_wdata_reg  <= wdata;
                        ready_reg      <= 1'b0;
                        if (NO_WAIT) begin
                            state_reg  <= RESP;
                            rvalid_reg <= 1'b1;
                        end else begin
                            state_reg    <= WAIT;
                            wait_cnt_reg <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg  <= RESP;
                        rvalid_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg  <= IDLE;
                    ready_reg  <= 1'b1;
                    rvalid_reg <= 1'b0;
                end
                default: begin
                    state_reg  <= IDLE;
                    ready_reg  <= 1'b1;
                    rvalid_reg <= 1'b0;
                end
            endcase

            // The result registers only change on the edge that enters
            // RESP. They therefore hold steady between responses.
            if (enter_resp) begin
                rdata_reg <= (fault || op_we) ? 32'd0 : load_data;
                err_reg   <= fault;
            end
        end
    end

    assign ready  = ready_reg;
    assign rvalid = rvalid_reg;
    assign rdata  = rdata_reg;
    assign err    = err_reg;

endmodule
